// File: rtl/butterfly_pkg.sv
// ---------------------------------------------------------------------------
// butterfly_pkg
// Shared types and defaults for the ButterFly data-memory slave.
//   dmem_state_e      : request FSM states (IDLE / WAIT / RESP)
//   DMEM_BASE_ADDR    : default byte address of word 0
//   DMEM_DEPTH_WORDS  : default array depth in 32-bit words
//   DMEM_WCNT_W       : width of the wait-state counter (WAIT_CYCLES 0..15)
// ---------------------------------------------------------------------------
package butterfly_pkg;

  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0001_0000;
  localparam int          DMEM_DEPTH_WORDS = 4096;
  localparam int          DMEM_WCNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_sram_if.sv
// ---------------------------------------------------------------------------
// dmem_sram_if
// Valid/ready data-memory bus between the core's data port and dmem_sram.
//   mem_valid_i  : request valid
//   mem_write_i  : 1 = store, 0 = load
//   mem_addr_i   : byte address (bits [1:0] ignored by the slave)
//   mem_wdata_i  : lane-aligned store data
//   mem_wstrb_i  : byte-lane write enables, bit n -> byte n
//   mem_rdata_o  : load data, valid while mem_ready_o
//   mem_ready_o  : one-cycle response pulse
//   mem_err_o    : access fault, valid while mem_ready_o
// Modports: master (requester side), slave (memory side).
// ---------------------------------------------------------------------------
interface dmem_sram_if;
  logic        mem_valid_i;
  logic        mem_write_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        mem_err_o;

  modport master (
    output mem_valid_i, mem_write_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    input  mem_rdata_o, mem_ready_o, mem_err_o
  );

  modport slave (
    input  mem_valid_i, mem_write_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
    output mem_rdata_o, mem_ready_o, mem_err_o
  );
endinterface

// File: rtl/dmem_ram_1rw.sv
// ---------------------------------------------------------------------------
// dmem_ram_1rw
// Single-port word array with per-byte write enables and a registered read.
//   clk   : clock
//   rst   : synchronous active-high, clears only the read register
//   we    : byte-lane write enables (all zero = no write)
//   re    : load the read register from the addressed word
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : read register; holds its value until the next re
// The storage itself is never reset.
// ---------------------------------------------------------------------------
module dmem_ram_1rw #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][b] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_sram.sv
// ---------------------------------------------------------------------------
// dmem_sram
// Single-port data memory slave with configurable wait states.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : dmem_sram_if.slave request/response bus
// Parameters:
//   DEPTH_WORDS : array depth in words (power of two)
//   BASE_ADDR   : byte address of word 0, aligned to 4*DEPTH_WORDS
//   WAIT_CYCLES : extra cycles between capture and response (0..15)
// Build option:
//   DMEM_BOUNDS_CHECK_EN : flag accesses outside the window with mem_err_o,
//                          drop faulting stores and return zero data.
//                          Undefined: index wraps, mem_err_o tied low.
// Flow: IDLE captures a request, WAIT burns WAIT_CYCLES-1 more cycles,
// the array is written/read on the edge entering RESP, RESP pulses ready.
// ---------------------------------------------------------------------------
module dmem_sram
  import butterfly_pkg::*;
#(
  parameter int          DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  dmem_sram_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_WCNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? DMEM_WCNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e            state, state_n;
  logic [DMEM_WCNT_W-1:0] cnt, cnt_n;
  logic                   capture;
  logic                   commit;

  // captured request
  logic          req_write;
  logic [AW-1:0] req_idx;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          req_fault;

  // live address decode
  logic [31:0] off;
  logic        live_fault;

  assign off = bus.mem_addr_i - BASE_ADDR;

`ifdef DMEM_BOUNDS_CHECK_EN
  // Base is window-aligned, so any set bit above the index means out of range
  // (addresses below the base wrap to a huge offset and also fail).
  assign live_fault = |off[31:AW+2];
  logic unused_off;
  assign unused_off = ^off[1:0];
`else
  assign live_fault = 1'b0;
  logic unused_off;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
`endif

  // ---- FSM -----------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_valid_i) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = RESP;
        else           cnt_n   = cnt - 1'b1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      req_write <= 1'b0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        req_write <= bus.mem_write_i;
        req_idx   <= off[AW+1:2];
        req_wdata <= bus.mem_wdata_i;
        req_wstrb <= bus.mem_wstrb_i;
        req_fault <= live_fault;
      end
    end
  end

  // ---- commit --------------------------------------------------------------
  // With zero wait states the commit edge is also the capture edge, so the
  // array sees the live bus in IDLE and the captured copy otherwise.
  logic          in_idle;
  logic          cur_write;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wstrb;
  logic          cur_fault;

  assign in_idle   = (state == IDLE);
  assign cur_write = in_idle ? bus.mem_write_i : req_write;
  assign cur_idx   = in_idle ? off[AW+1:2]     : req_idx;
  assign cur_wdata = in_idle ? bus.mem_wdata_i : req_wdata;
  assign cur_wstrb = in_idle ? bus.mem_wstrb_i : req_wstrb;
  assign cur_fault = in_idle ? live_fault      : req_fault;

  // RESP is only ever entered from IDLE or WAIT, so this marks the commit edge.
  assign commit = (state_n == RESP);

  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_q;

  // Reset on the commit edge suppresses the write.
  assign ram_we = (commit && cur_write && !cur_fault && !rst_i) ? cur_wstrb : 4'b0000;
  assign ram_re = commit && !cur_write && !cur_fault && !rst_i;

  dmem_ram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  // ---- response ------------------------------------------------------------
  assign bus.mem_ready_o = (state == RESP);

`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_q;
  logic rd_fault;   // last response faulted: present zero until the next good load

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q    <= 1'b0;
      rd_fault <= 1'b0;
    end else begin
      err_q <= commit && cur_fault;
      if (commit && cur_fault)       rd_fault <= 1'b1;
      else if (commit && !cur_write) rd_fault <= 1'b0;
    end
  end

  assign bus.mem_err_o   = err_q;
  assign bus.mem_rdata_o = rd_fault ? 32'h0 : ram_q;
`else
  assign bus.mem_err_o   = 1'b0;
  assign bus.mem_rdata_o = ram_q;
`endif

endmodule

// File: tb/tb_dmem_sram.sv
// ---------------------------------------------------------------------------
// tb_dmem_sram
// Three dmem_sram instances (WAIT_CYCLES = 1, 0, 4) share request wires; each
// has its own valid and reset. Expected responses (data, err, arrival cycle)
// are queued when a request is driven and popped when ready is seen.
// ---------------------------------------------------------------------------
module tb_dmem_sram;

  localparam int NDUT = 3;

  function automatic int wait_of(int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NDUT-1:0] rst, vld;
  logic            wr;
  logic [31:0]     addr, wdata;
  logic [3:0]      strb;
  logic [NDUT-1:0] rdy, err;
  logic [31:0]     rd [NDUT];

  dmem_sram_if b0 ();
  dmem_sram_if b1 ();
  dmem_sram_if b2 ();

  assign b0.mem_valid_i = vld[0];
  assign b0.mem_write_i = wr;
  assign b0.mem_addr_i  = addr;
  assign b0.mem_wdata_i = wdata;
  assign b0.mem_wstrb_i = strb;
  assign b1.mem_valid_i = vld[1];
  assign b1.mem_write_i = wr;
  assign b1.mem_addr_i  = addr;
  assign b1.mem_wdata_i = wdata;
  assign b1.mem_wstrb_i = strb;
  assign b2.mem_valid_i = vld[2];
  assign b2.mem_write_i = wr;
  assign b2.mem_addr_i  = addr;
  assign b2.mem_wdata_i = wdata;
  assign b2.mem_wstrb_i = strb;

  assign rdy[0] = b0.mem_ready_o;
  assign rdy[1] = b1.mem_ready_o;
  assign rdy[2] = b2.mem_ready_o;
  assign err[0] = b0.mem_err_o;
  assign err[1] = b1.mem_err_o;
  assign err[2] = b2.mem_err_o;
  assign rd[0]  = b0.mem_rdata_o;
  assign rd[1]  = b1.mem_rdata_o;
  assign rd[2]  = b2.mem_rdata_o;

  dmem_sram #(.WAIT_CYCLES(1)) u_w1 (.clk_i(clk), .rst_i(rst[0]), .bus(b0));
  dmem_sram #(.WAIT_CYCLES(0)) u_w0 (.clk_i(clk), .rst_i(rst[1]), .bus(b1));
  dmem_sram #(.WAIT_CYCLES(4)) u_w4 (.clk_i(clk), .rst_i(rst[2]), .bus(b2));

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] last_rd [NDUT];
  int          checks = 0;
  int          errors = 0;

  // Model: loads update the held read value, stores leave it, faults zero it.
  task automatic push_exp(int d, bit w, logic [31:0] exp_rd, bit exp_err, int exp_cyc);
    exp_t e;
    if (exp_err)  last_rd[d] = 32'h0;
    else if (!w)  last_rd[d] = exp_rd;
    e.cyc = exp_cyc;
    e.rd  = last_rd[d];
    e.err = exp_err;
    sbq.push_back(e);
  endtask

  task automatic pop_check(int d);
    exp_t e;
    e = sbq.pop_front();
    checks += 3;
    if (cyc !== e.cyc) begin
      errors++;
      $display("FAIL resp_cycle dut%0d: got cycle %0d, expected %0d", d, cyc, e.cyc);
    end
    if (rd[d] !== e.rd) begin
      errors++;
      $display("FAIL resp_rdata dut%0d: got %h, expected %h", d, rd[d], e.rd);
    end
    if (err[d] !== e.err) begin
      errors++;
      $display("FAIL resp_err dut%0d: got %b, expected %b", d, err[d], e.err);
    end
  endtask

  task automatic drain(int d);
    int budget = 0;
    while (sbq.size() != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (rdy[d]) pop_check(d);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL resp_timeout dut%0d: %0d outstanding, expected 0", d, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    checks++;
    if (rdy[d] !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse dut%0d: ready got %b after response, expected 0", d, rdy[d]);
    end
  endtask

  // Drive one request, then scramble the bus so only the captured copy is valid.
  task automatic do_req(int d, bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
                        logic [31:0] exp_rd, bit exp_err);
    @(negedge clk);
    wr = w; addr = a; wdata = wd; strb = s; vld[d] = 1'b1;
    push_exp(d, w, exp_rd, exp_err, cyc + wait_of(d) + 1);
    @(posedge clk);
    #1;
    vld[d] = 1'b0; wr = ~w; addr = ~a; wdata = ~wd; strb = ~s;
    drain(d);
  endtask

  task automatic test_reset;
    rst = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks += 3;
      if (rdy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready dut%0d: got %b, expected 0", d, rdy[d]);
      end
      if (rd[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata dut%0d: got %h, expected 0", d, rd[d]);
      end
      if (err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_err dut%0d: got %b, expected 0", d, err[d]);
      end
    end
    rst = '0;
  endtask

  task automatic test_basic;
    do_req(0, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h0001_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_byte_lane;
    do_req(0, 1'b1, 32'h0001_0020, 32'h1122_3344, 4'hF,    32'h0, 1'b0);
    do_req(0, 1'b1, 32'h0001_0020, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h0001_0020, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0);
  endtask

  task automatic test_zero_strb;
    do_req(0, 1'b1, 32'h0001_0030, 32'h600D_CAFE, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b1, 32'h0001_0030, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h0001_0030, 32'h0,         4'h0, 32'h600D_CAFE, 1'b0);
  endtask

  task automatic test_out_of_range;
    do_req(0, 1'b1, 32'h0001_0000, 32'h5A5A_0001, 4'hF, 32'h0, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    do_req(0, 1'b0, 32'h0002_0000, 32'h0,         4'h0, 32'h0, 1'b1);
    do_req(0, 1'b1, 32'h0002_0000, 32'h7777_7777, 4'hF, 32'h0, 1'b1);
    do_req(0, 1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 32'h0, 1'b1);
    do_req(0, 1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h5A5A_0001, 1'b0);
`else
    do_req(0, 1'b0, 32'h0002_0000, 32'h0,         4'h0, 32'h5A5A_0001, 1'b0);
    do_req(0, 1'b1, 32'h0002_0000, 32'h7777_7777, 4'hF, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h7777_7777, 1'b0);
`endif
  endtask

  // Zero wait states, valid held high across three loads.
  task automatic test_back_to_back;
    logic [31:0] a [3];
    logic [31:0] v [3];
    int          budget;
    a = '{32'h0001_0100, 32'h0001_0104, 32'h0001_0108};
    v = '{32'h0102_0304, 32'hA5A5_5A5A, 32'hFEDC_BA98};
    for (int i = 0; i < 3; i++) do_req(1, 1'b1, a[i], v[i], 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    wr = 1'b0; addr = a[0]; wdata = 32'h0; strb = 4'h0; vld[1] = 1'b1;
    push_exp(1, 1'b0, v[0], 1'b0, cyc + 1);
    for (int i = 0; i < 3; i++) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!rdy[1] && budget < 10);
      checks++;
      if (!rdy[1]) begin
        errors++;
        $display("FAIL b2b_timeout load%0d: ready got 0, expected 1", i);
        sbq.delete();
        break;
      end
      pop_check(1);
      if (i < 2) begin
        addr = a[i+1];
        push_exp(1, 1'b0, v[i+1], 1'b0, cyc + 2);
      end
    end
    vld[1] = 1'b0;
    sbq.delete();
    @(negedge clk);
  endtask

  // Store aborted by reset; rst_cyc = cycle (after capture) in which rst is high.
  task automatic reset_abort(int rst_cyc, logic [31:0] a, logic [31:0] dat, string tag);
    bit seen = 1'b0;
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = dat; strb = 4'hF; vld[2] = 1'b1;
    @(posedge clk);
    #1;
    vld[2] = 1'b0;
    repeat (rst_cyc) begin
      @(negedge clk);
      seen |= rdy[2];
    end
    rst[2] = 1'b1;
    last_rd[2] = 32'h0;
    @(negedge clk);
    seen |= rdy[2];
    rst[2] = 1'b0;
    checks += 2;
    if (rd[2] !== 32'h0) begin
      errors++;
      $display("FAIL %s_rdata: got %h, expected 0", tag, rd[2]);
    end
    if (err[2] !== 1'b0) begin
      errors++;
      $display("FAIL %s_err: got %b, expected 0", tag, err[2]);
    end
    repeat (8) begin
      @(negedge clk);
      seen |= rdy[2];
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s_ready: got a ready pulse, expected none", tag);
    end
  endtask

  task automatic test_reset_mid_wait;
    do_req(2, 1'b1, 32'h0001_0040, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    do_req(2, 1'b0, 32'h0001_0040, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    reset_abort(2, 32'h0001_0040, 32'hCAFE_F00D, "rst_wait");
    do_req(2, 1'b0, 32'h0001_0040, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_reset_at_commit;
    reset_abort(4, 32'h0001_0040, 32'h0BAD_BEEF, "rst_commit");
    do_req(2, 1'b0, 32'h0001_0040, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
  endtask

  initial begin
    rst   = '1;
    vld   = '0;
    wr    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    strb  = 4'h0;
    for (int d = 0; d < NDUT; d++) last_rd[d] = 32'h0;

    test_reset;
    test_basic;
    test_byte_lane;
    test_zero_strb;
    test_out_of_range;
    test_back_to_back;
    test_reset_mid_wait;
    test_reset_at_commit;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
